sd_cmd_phy: RTL and testbench

SD CMD-line physical stage, directly downstream of the CMD control block.
- Takes a command index and argument, builds the 48-bit command token with CRC7, and shifts it MSB-first onto the CMD line.
- Optionally waits for and deserializes the 48-bit card response.
- Returns the response, a done pulse and timeout/CRC status to the control block.
- Runs entirely in the SD clock domain.

---
 rtl/sd_cmd_phy.sv | 171 +++++++++++++++++
 tb/tb_sd_cmd_phy.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_phy.sv
// SD CMD-line physical stage: builds and shifts out the 48-bit command token, then optionally captures the 48-bit response.
// Optional receive-side CRC7/end-bit check is enabled with `define RESP_CRC_CHECK_EN.
module sd_cmd_phy #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TURN_CYCLES    = 2
) (
  input  logic        iClock_SD,
  input  logic        iReset,
  input  logic        iLoad_send,
  input  logic [5:0]  iCmd_index,
  input  logic [31:0] iCmd_argument,
  input  logic        iResponse_expected,
  input  logic        iTimeout_enable,
  input  logic        iSerial_from_card,
  output logic        oSerial_to_card,
  output logic        oSerial_oe,
  output logic        oBusy,
  output logic        oFrame_done,
  output logic        oResponse_valid,
  output logic [47:0] oResponse,
  output logic        oTimeout,
  output logic        oCrc_error
);

  typedef enum logic [2:0] {IDLE, SEND, TURN, WAIT_START, RECEIVE, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + TURN_CYCLES + 48) + 1;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [47:0]   tx_sr;
  logic [46:0]   rx_sr;
  logic [47:0]   resp;
  logic          resp_exp;
  logic          got_resp;
  logic          timeout;
  logic          last_send, last_turn, last_rx, start_seen, limit;
  logic [39:0]   tx_head;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 40; i++) begin
      fb = d[39-i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign tx_head    = {1'b0, 1'b1, iCmd_index, iCmd_argument};
  assign last_send  = (cnt == CW'(47));
  assign last_turn  = (cnt == CW'(TURN_CYCLES - 1));
  assign last_rx    = (cnt == CW'(46));
  assign start_seen = !iSerial_from_card;
  assign limit      = iTimeout_enable && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iClock_SD) begin
    if (!iReset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (iLoad_send) state_next = SEND;
      SEND:       if (last_send) state_next = resp_exp ? TURN : DONE;
      TURN:       if (last_turn) state_next = WAIT_START;
      // a start bit on the limit cycle takes priority over the timeout
      WAIT_START: if (start_seen) state_next = RECEIVE;
                  else if (limit) state_next = IDLE;
      RECEIVE:    if (last_rx) state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    oSerial_to_card = 1'b1;
    oSerial_oe      = 1'b0;
    oBusy           = 1'b1;
    oFrame_done     = 1'b0;
    oResponse_valid = 1'b0;
    case (state)
      IDLE: oBusy = 1'b0;
      SEND: begin
        oSerial_oe      = 1'b1;
        oSerial_to_card = tx_sr[47];
      end
      DONE: begin
        oFrame_done     = 1'b1;
        oResponse_valid = got_resp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClock_SD) begin
    if (!iReset) begin
      cnt      <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      resp     <= '0;
      resp_exp <= 1'b0;
      got_resp <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (iLoad_send) begin
            tx_sr    <= {tx_head, crc7(tx_head), 1'b1};
            resp_exp <= iResponse_expected;
            got_resp <= 1'b0;
          end
        end
        SEND: begin
          tx_sr <= {tx_sr[46:0], 1'b1};
          cnt   <= last_send ? '0 : cnt + CW'(1);
        end
        TURN: cnt <= last_turn ? '0 : cnt + CW'(1);
        WAIT_START: begin
          if (start_seen) begin
            rx_sr <= '0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
            if (limit) timeout <= 1'b1;
          end
        end
        RECEIVE: begin
          rx_sr <= {rx_sr[45:0], iSerial_from_card};
          cnt   <= cnt + CW'(1);
          if (last_rx) begin
            resp     <= {rx_sr, iSerial_from_card};
            got_resp <= 1'b1;
          end
        end
        DONE:    cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

`ifdef RESP_CRC_CHECK_EN
  logic        crc_err;
  logic [47:0] rx_word;

  assign rx_word = {rx_sr, iSerial_from_card};

  always_ff @(posedge iClock_SD) begin
    if (!iReset) begin
      crc_err <= 1'b0;
    end else if (state == IDLE && iLoad_send) begin
      crc_err <= 1'b0;
    end else if (state == RECEIVE && last_rx) begin
      crc_err <= (crc7(rx_word[47:8]) != rx_word[7:1]) || !rx_word[0];
    end
  end

  assign oCrc_error = crc_err;
`else
  assign oCrc_error = 1'b0;
`endif

  assign oResponse = resp;
  assign oTimeout  = timeout;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Directed self-checking bench for sd_cmd_phy: token serialisation, response capture, CRC status, timeout and reset abort.
module tb_sd_cmd_phy;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic        resp_exp;
  logic        timeout_en;
  logic        ser_in;
  logic        ser_out;
  logic        oe;
  logic        busy;
  logic        frame_done;
  logic        resp_valid;
  logic [47:0] response;
  logic        timeout;
  logic        crc_error;

  int checks   = 0;
  int failures = 0;

  localparam logic [47:0] TOK_CMD0 = 48'h400000000095;
  localparam logic [47:0] TOK_CMD8 = 48'h48000001AA87;
  localparam logic [47:0] RESP_R7  = 48'h08000001AA13;

`ifdef RESP_CRC_CHECK_EN
  localparam logic BAD_CRC_EXP = 1'b1;
`else
  localparam logic BAD_CRC_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  sd_cmd_phy #(.TIMEOUT_CYCLES(64), .TURN_CYCLES(2)) dut (
    .iClock_SD          (clk),
    .iReset             (rst_n),
    .iLoad_send         (load),
    .iCmd_index         (cmd_index),
    .iCmd_argument      (cmd_argument),
    .iResponse_expected (resp_exp),
    .iTimeout_enable    (timeout_en),
    .iSerial_from_card  (ser_in),
    .oSerial_to_card    (ser_out),
    .oSerial_oe         (oe),
    .oBusy              (busy),
    .oFrame_done        (frame_done),
    .oResponse_valid    (resp_valid),
    .oResponse          (response),
    .oTimeout           (timeout),
    .oCrc_error         (crc_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Applies a one-cycle load; returns in the first SEND cycle.
  task automatic load_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic rexp);
    cmd_index    = idx;
    cmd_argument = arg;
    resp_exp     = rexp;
    load         = 1'b1;
    step();
    load         = 1'b0;
  endtask

  // Samples the 48 SEND cycles; returns in the last one.
  task automatic collect(output logic [47:0] tok, output logic line_ok);
    tok     = '0;
    line_ok = 1'b1;
    for (int unsigned i = 0; i < 48; i++) begin
      if (i != 0) step();
      tok = {tok[46:0], ser_out};
      if (!oe || frame_done || !busy) line_ok = 1'b0;
    end
  endtask

  // From the last SEND cycle: turnaround, wait_n idle cycles, then the response MSB-first; returns in DONE.
  task automatic respond(input logic [47:0] word, input int unsigned wait_n);
    step();
    check("turn_oe", oe, 1'b0);
    check("turn_line", ser_out, 1'b1);
    step();
    step();
    for (int unsigned i = 0; i < wait_n; i++) begin
      ser_in = 1'b1;
      step();
    end
    for (int unsigned i = 0; i < 48; i++) begin
      ser_in = word[47-i];
      step();
    end
    ser_in = 1'b1;
  endtask

  initial begin
    logic [47:0] tok;
    logic [47:0] bad;
    logic [26:0] part;
    logic        ok;
    logic        seen;

    rst_n        = 1'b0;
    load         = 1'b1;
    cmd_index    = 6'd0;
    cmd_argument = '0;
    resp_exp     = 1'b0;
    timeout_en   = 1'b1;
    ser_in       = 1'b1;
    repeat (3) step();
    check("rst_line", ser_out, 1'b1);
    check("rst_oe", oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_valid", resp_valid, 1'b0);
    check("rst_resp", response, 48'h0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_crc", crc_error, 1'b0);
    rst_n = 1'b1;
    load  = 1'b0;
    step();
    check("no_send_after_rst", busy, 1'b0);

    // CMD0, no response
    load_cmd(6'd0, 32'h0, 1'b0);
    collect(tok, ok);
    check("cmd0_token", tok, TOK_CMD0);
    check("cmd0_line_ctl", ok, 1'b1);
    step();
    check("cmd0_done", frame_done, 1'b1);
    check("cmd0_valid", resp_valid, 1'b0);
    check("cmd0_busy_in_done", busy, 1'b1);
    step();
    check("cmd0_done_pulse", frame_done, 1'b0);
    check("cmd0_idle", busy, 1'b0);

    // CMD8 with valid R7 response
    load_cmd(6'd8, 32'h000001AA, 1'b1);
    collect(tok, ok);
    check("cmd8_token", tok, TOK_CMD8);
    check("cmd8_line_ctl", ok, 1'b1);
    respond(RESP_R7, 5);
    check("r7_done", frame_done, 1'b1);
    check("r7_valid", resp_valid, 1'b1);
    check("r7_resp", response, RESP_R7);
    check("r7_crc", crc_error, 1'b0);
    step();
    check("r7_done_pulse", frame_done, 1'b0);
    check("r7_valid_pulse", resp_valid, 1'b0);
    check("r7_resp_held", response, RESP_R7);

    // Corrupted response bit 20
    bad = RESP_R7 ^ 48'h000000100000;
    load_cmd(6'd8, 32'h000001AA, 1'b1);
    collect(tok, ok);
    respond(bad, 5);
    check("bad_done", frame_done, 1'b1);
    check("bad_resp", response, bad);
    check("bad_crc", crc_error, BAD_CRC_EXP);
    step();
    check("bad_crc_held", crc_error, BAD_CRC_EXP);

    // Timeout with line held high
    load_cmd(6'd8, 32'h000001AA, 1'b1);
    check("crc_clr_on_load", crc_error, 1'b0);
    collect(tok, ok);
    step();
    step();
    step();
    seen = 1'b0;
    for (int unsigned i = 0; i < 63; i++) begin
      if (timeout || frame_done) seen = 1'b1;
      step();
    end
    check("to_early", seen, 1'b0);
    check("to_busy_last_wait", busy, 1'b1);
    step();
    check("to_pulse", timeout, 1'b1);
    check("to_idle", busy, 1'b0);
    check("to_no_done", frame_done, 1'b0);
    step();
    check("to_pulse_end", timeout, 1'b0);

    // Timeout disabled: waits indefinitely
    timeout_en = 1'b0;
    load_cmd(6'd8, 32'h000001AA, 1'b1);
    collect(tok, ok);
    seen = 1'b0;
    for (int unsigned i = 0; i < 500; i++) begin
      step();
      if (timeout || !busy) seen = 1'b1;
    end
    check("noto_still_busy", seen, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("noto_rst_idle", busy, 1'b0);
    timeout_en = 1'b1;

    // Mid-SEND load ignored, reset at bit 20
    load_cmd(6'd8, 32'h000001AA, 1'b1);
    part = '0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (i != 0) step();
      part = {part[25:0], ser_out};
      if (i == 5) begin
        cmd_index    = 6'd0;
        cmd_argument = 32'hFFFFFFFF;
        load         = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    tok = TOK_CMD8;
    check("abort_partial", part, tok[47:21]);
    step();
    check("abort_bit20", ser_out, tok[20]);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_oe", oe, 1'b0);
    check("abort_line", ser_out, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_no_done", frame_done, 1'b0);
    load_cmd(6'd0, 32'h0, 1'b0);
    collect(tok, ok);
    check("post_abort_token", tok, TOK_CMD0);
    step();
    check("post_abort_done", frame_done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
